tqvp_reg_arbiter: RTL
=====================

// Module: tqvp_reg_arbiter
// PURPOSE
//   Shares the single peripheral register port (address/data_in/data_write_n/data_read_n/
//   data_out/data_ready) between two requesters: m0 = SPI register bridge, m1 = on-chip
//   test sequencer. Round-robin arbitration, one transaction in flight at a time, read
//   data masked to the transaction width, read timeout with error return.
// PARAMETERS
//   ADDR_W   6    register address width
//   TIMEOUT  64   max cycles a read waits for data_ready before error completion (>=2)
// PORTS
//   clk           in   1       clock
//   rst           in   1       synchronous reset, active high
//   mN_req        in   1       N=0,1: request; held high until mN_ack
//   mN_rw         in   1       1=write, 0=read
//   mN_txn        in   2       00 byte, 01 half, 10 word, 11 illegal
//   mN_addr       in   ADDR_W  register address
//   mN_wdata      in   32      write data
//   mN_ack        out  1       one-cycle completion pulse
//   mN_rdata      out  32      read data, valid with mN_ack
//   mN_err        out  1       error flag, valid with mN_ack
//   busy          out  1       high in any state other than IDLE
//   address       out  ADDR_W  to peripheral
//   data_in       out  32      to peripheral (write data)
//   data_write_n  out  2       write strobe; 11 = none, else txn width
//   data_read_n   out  2       read strobe; 11 = none, else txn width
//   data_out      in   32      from peripheral
//   data_ready    in   1       read data valid from peripheral
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=1 (m0 wins first tie), address=0, data_in=0,
//     data_write_n=data_read_n=11, mN_ack=0, mN_rdata=0, mN_err=0, busy=0, timer=0.
//   All outputs registered; strobes driven from latched txn registers, never from mN_* directly.
//   FSM IDLE -> WRITE|READ|ACK -> ACK -> IDLE:
//   - IDLE: if one req high, grant it; if both high, grant !last_grant. Latch
//     rw/txn/addr/wdata, set last_grant. txn=11 -> ACK with err=1, no peripheral strobe.
//     Else rw=1 -> WRITE, rw=0 -> READ, timer cleared.
//   - WRITE: data_write_n=txn for exactly 1 cycle -> ACK, err=0.
//   - READ: data_read_n=txn held every cycle until data_ready=1 (sampled same cycle,
//     incl. first READ cycle). Capture data_out masked: txn 00 -> [31:8]=0; 01 -> [31:16]=0;
//     10 -> unmasked. -> ACK. timer increments each READ cycle; data_ready still 0 when
//     timer==TIMEOUT-1 -> ACK with err=1, rdata=0 (data_ready wins if same cycle).
//   - ACK: strobes 11; granted mN_ack=1 for 1 cycle with rdata/err; -> IDLE.
//     Non-granted requester sees ack=0; its pending req is served next IDLE.
//   mN_rdata/mN_err hold their value until that requester's next ack.
//   Latency: write req-to-ack 2 cycles; read = 2 + (cycles data_ready stays low).
//   Requester drops req the cycle after ack; req still high in IDLE is a new request.
//   Back-to-back both-requesting: strict alternation m0,m1,m0,... (one IDLE gap each).
//   Requester deasserting req mid-transaction: ignored, transaction completes and acks.
//   data_ready outside READ: ignored. rst mid-transaction: next cycle all strobes 11,
//     state IDLE, no ack issued for the aborted transaction.
// TESTING
//   m0 write word addr 5 data 0xDEADBEEF -> data_write_n=10 one cycle, address=5, data_in=0xDEADBEEF, m0_ack 2 cycles after req.
//   m1 byte read, data_out=0x12345678, data_ready same cycle as strobe -> m1_rdata=0x00000078, err=0, ack 2 cycles after req.
//   m0,m1 both req writes in same cycle from reset, held -> m0 served first, then m1, then m0 again.
//   Read with data_ready never high, TIMEOUT=64 -> data_read_n=00/01/10 for 64 cycles, then ack err=1 rdata=0.
//   m1 txn=11 -> ack err=1 after 1 cycle, data_write_n/data_read_n stay 11.
//   rst pulsed during READ wait -> strobes 11 next cycle, busy=0, no ack; next req served normally.

Source files
------------

// File: rtl/tqvp_reg_arbiter.sv
// Two-requester round-robin arbiter for the single peripheral register port.
// One transaction in flight; reads are width-masked and time out with an error.

module tqvp_reg_arbiter_rsp (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [31:0] rdata_in,
  input  logic        err_in,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);
  // rdata/err are sticky between this requester's own acks
  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ack <= set;
      if (set) begin
        rdata <= rdata_in;
        err   <= err_in;
      end
    end
  end
endmodule

module tqvp_reg_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [1:0]        m0_txn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [1:0]        m1_txn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [31:0]       data_out,
  input  logic              data_ready
);
  localparam int NUM_REQ = 2;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        txn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  function automatic logic [31:0] mask_rd(input logic [1:0] t, input logic [31:0] d);
    case (t)
      2'b00:   return {24'h0, d[7:0]};
      2'b01:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_t state, state_n;
  logic   last_grant, last_n;
  logic   grant, grant_n;
  req_t   cur, cur_n;
  logic [TW-1:0] timer, timer_n;
  logic   busy_n;
  logic [1:0] wr_n, rd_n;
  logic [31:0] res_data;
  logic        res_err;
  logic [NUM_REQ-1:0] ack_set;
  logic [NUM_REQ-1:0] req;
  req_t [NUM_REQ-1:0] rq;
  logic g;

  always_comb begin
    req   = {m1_req, m0_req};
    rq[0] = {m0_rw, m0_txn, m0_addr, m0_wdata};
    rq[1] = {m1_rw, m1_txn, m1_addr, m1_wdata};
  end

  always_comb begin
    state_n  = state;
    last_n   = last_grant;
    grant_n  = grant;
    cur_n    = cur;
    timer_n  = timer;
    res_data = '0;
    res_err  = 1'b0;
    ack_set  = '0;
    g        = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          // on a tie, the requester that did not win last time goes first
          g       = (req[0] && req[1]) ? ~last_grant : req[1];
          grant_n = g;
          last_n  = g;
          cur_n   = rq[g];
          timer_n = '0;
          if (rq[g].txn == 2'b11) begin
            state_n    = ACK;
            res_err    = 1'b1;
            ack_set[g] = 1'b1;
          end else begin
            state_n = rq[g].rw ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        state_n        = ACK;
        ack_set[grant] = 1'b1;
      end
      READ: begin
        if (data_ready) begin
          state_n        = ACK;
          res_data       = mask_rd(cur.txn, data_out);
          ack_set[grant] = 1'b1;
        end else if (timer == T_LAST) begin
          state_n        = ACK;
          res_err        = 1'b1;
          ack_set[grant] = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // strobes follow the latched transaction, registered with the state
    wr_n   = (state_n == WRITE) ? cur_n.txn : 2'b11;
    rd_n   = (state_n == READ)  ? cur_n.txn : 2'b11;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      cur          <= '0;
      timer        <= '0;
      busy         <= 1'b0;
      data_write_n <= 2'b11;
      data_read_n  <= 2'b11;
    end else begin
      state        <= state_n;
      last_grant   <= last_n;
      grant        <= grant_n;
      cur          <= cur_n;
      timer        <= timer_n;
      busy         <= busy_n;
      data_write_n <= wr_n;
      data_read_n  <= rd_n;
    end
  end

  assign address = cur.addr;
  assign data_in = cur.wdata;

  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0][31:0] rdata;
  logic [NUM_REQ-1:0]       err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    tqvp_reg_arbiter_rsp u_rsp (
      .clk      (clk),
      .rst      (rst),
      .set      (ack_set[i]),
      .rdata_in (res_data),
      .err_in   (res_err),
      .ack      (ack[i]),
      .rdata    (rdata[i]),
      .err      (err[i])
    );
  end

  assign m0_ack   = ack[0];
  assign m0_rdata = rdata[0];
  assign m0_err   = err[0];
  assign m1_ack   = ack[1];
  assign m1_rdata = rdata[1];
  assign m1_err   = err[1];
endmodule
